// File: rtl/num_entry_ctrl.sv
// Operand-entry controller for the 24 game: collects NUM_COUNT decimal operands from keypad strobes.
// Optional feature: define BACKSPACE_EN to enable key B as a digit backspace.
module num_entry_ctrl #(
    parameter int NUM_COUNT = 4,
    parameter int NUM_W     = 10,
    parameter int MAX_VAL   = 999
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       restart,
    input  logic [3:0]                 key,
    input  logic                       key_stb,
    output logic [NUM_COUNT*NUM_W-1:0] nums,
    output logic [NUM_COUNT-1:0]       valid,
    output logic [$clog2(NUM_COUNT+1)-1:0] cur_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int CW = $clog2(NUM_COUNT + 1);
    localparam int IW = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;
    localparam int VW = NUM_W + 4;

    // State bit 0 doubles as busy and bit 1 as done, so both outputs come straight from flops.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ENTRY = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t              state_r;
    logic [NUM_W-1:0]    slots_r [NUM_COUNT];
    logic [NUM_COUNT-1:0] valid_r;
    logic [CW-1:0]       cur_idx_r;
    logic [7:0]          dcnt_r;
    logic                err_r;
    logic                start_q_r;
    logic                restart_q_r;

    logic                start_re_s;
    logic                restart_re_s;
    logic [IW-1:0]       idx_s;
    logic [NUM_W-1:0]    cur_val_s;
    logic [VW-1:0]       cand_s;
    logic                digit_ok_s;
    logic                is_last_s;
`ifdef BACKSPACE_EN
    logic [VW-1:0]       bs_full_s;
    logic [NUM_W-1:0]    bs_val_s;
`endif

    // Edge detection and candidate values for the slot under edit.
    always_comb begin
        start_re_s   = start & ~start_q_r;
        restart_re_s = restart & ~restart_q_r;
        idx_s        = cur_idx_r[IW-1:0];
        cur_val_s    = slots_r[idx_s];
        cand_s       = {4'b0000, cur_val_s} * VW'(10) + {{(VW-4){1'b0}}, key};
        digit_ok_s   = (cand_s <= VW'(MAX_VAL));
        is_last_s    = (cur_idx_r == CW'(NUM_COUNT - 1));
`ifdef BACKSPACE_EN
        bs_full_s    = {4'b0000, cur_val_s} / VW'(10);
        bs_val_s     = bs_full_s[NUM_W-1:0];
`endif
    end

    // Pack operand slots onto the flat output bus.
    always_comb begin
        nums = '0;
        for (int i = 0; i < NUM_COUNT; i++) begin
            nums[i*NUM_W +: NUM_W] = slots_r[i];
        end
    end

    assign valid   = valid_r;
    assign cur_idx = cur_idx_r;
    assign busy    = state_r[0];
    assign done    = state_r[1];
    assign err     = err_r;

    // Round FSM with operand datapath; restart has priority over everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            for (int i = 0; i < NUM_COUNT; i++) slots_r[i] <= '0;
            valid_r     <= '0;
            cur_idx_r   <= '0;
            dcnt_r      <= 8'd0;
            err_r       <= 1'b0;
            start_q_r   <= 1'b0;
            restart_q_r <= 1'b0;
        end else begin
            start_q_r   <= start;
            restart_q_r <= restart;
            err_r       <= 1'b0;
            if (restart_re_s) begin
                state_r   <= ST_IDLE;
                for (int i = 0; i < NUM_COUNT; i++) slots_r[i] <= '0;
                valid_r   <= '0;
                cur_idx_r <= '0;
                dcnt_r    <= 8'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_re_s) begin
                            state_r   <= ST_ENTRY;
                            for (int i = 0; i < NUM_COUNT; i++) slots_r[i] <= '0;
                            valid_r   <= '0;
                            cur_idx_r <= '0;
                            dcnt_r    <= 8'd0;
                        end
                    end
                    ST_ENTRY: begin
                        if (key_stb) begin
                            case (key)
                                4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                                    if (digit_ok_s) begin
                                        slots_r[idx_s] <= cand_s[NUM_W-1:0];
                                        // Saturate: only the zero/non-zero distinction matters.
                                        if (dcnt_r != 8'hFF) dcnt_r <= dcnt_r + 8'd1;
                                    end else begin
                                        err_r <= 1'b1;
                                    end
                                end
                                4'hA: begin
                                    if (dcnt_r == 8'd0) begin
                                        err_r <= 1'b1;
                                    end else begin
                                        valid_r[idx_s] <= 1'b1;
                                        dcnt_r         <= 8'd0;
                                        cur_idx_r      <= cur_idx_r + CW'(1);
                                        if (is_last_s) state_r <= ST_DONE;
                                    end
                                end
`ifdef BACKSPACE_EN
                                4'hB: begin
                                    if (dcnt_r == 8'd0) begin
                                        err_r <= 1'b1;
                                    end else begin
                                        slots_r[idx_s] <= bs_val_s;
                                        dcnt_r         <= dcnt_r - 8'd1;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                    ST_DONE: ;
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
